// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg: shared widths and state encodings for the round-robin arbiter
package rr_arbiter_8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int HOLD_W = 4;
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_grant_decode.sv
// rr_grant_decode: enabled 3-to-8 one-hot decode of the grant index
module rr_grant_decode
  import rr_arbiter_8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] gnt
);
  assign gnt = en ? onehot(idx) : '0;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a bounded hold time under contention
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
    $error("rr_arbiter_8: MAX_HOLD must be within 1..15");
  end
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, win, cand;
  logic [HOLD_W-1:0] hold_cnt;
  logic found, others, rotate, take;
  // ptr always equals the holder while granted, so one search from ptr+1 serves both release and rotation
  always_comb begin
    found = 1'b0;
    win = ptr;
    cand = ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  always_comb begin
    others = |(req & ~onehot(gnt_idx));
    rotate = hold_cnt == HOLD_LAST && req[gnt_idx] && others;
    take = found && (state == ST_IDLE || !req[gnt_idx] || rotate);
    state_n = take || (state == ST_GRANT && req[gnt_idx]) ? ST_GRANT : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
      gnt_idx <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        ptr <= win;
        gnt_idx <= win;
        hold_cnt <= '0;
      end else if (state == ST_IDLE) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
  assign gnt_valid = state == ST_GRANT;
  rr_grant_decode u_dec (
    .idx(gnt_idx),
    .en (gnt_valid),
    .gnt(gnt)
  );
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench driving directed request vectors with hand-computed grants
module tb_rr_arbiter_8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid;
  typedef struct {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] eg,
                      input logic [2:0] ei, input logic ev);
    @(negedge clk);
    rst = r;
    req = rq;
    q.push_back('{g: eg, i: ei, v: ev});
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if (gnt !== e.g) begin
          miscompares++;
          $display("FAIL gnt vec%0d: got %h want %h", vectors, gnt, e.g);
        end
        if (gnt_idx !== e.i) begin
          miscompares++;
          $display("FAIL gnt_idx vec%0d: got %0d want %0d", vectors, gnt_idx, e.i);
        end
        if (gnt_valid !== e.v) begin
          miscompares++;
          $display("FAIL gnt_valid vec%0d: got %b want %b", vectors, gnt_valid, e.v);
        end
      end
    end
  end
  initial begin : driver
    int budget;
    step(1, 8'hFF, 8'h00, 0, 0);
    step(1, 8'hFF, 8'h00, 0, 0);
    step(0, 8'hFF, 8'h01, 0, 1);
    step(0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h04, 8'h04, 2, 1);
    for (int k = 0; k < 6; k++) step(0, 8'h04, 8'h04, 2, 1);
    step(0, 8'h00, 8'h00, 2, 0);
    step(1, 8'h00, 8'h00, 0, 0);
    for (int k = 0; k < 36; k++) step(0, 8'hFF, 8'h01 << ((k / 4) % 8), 3'((k / 4) % 8), 1);
    step(0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h08, 8'h08, 3, 1);
    step(0, 8'h2A, 8'h08, 3, 1);
    step(0, 8'h22, 8'h20, 5, 1);
    step(0, 8'h02, 8'h02, 1, 1);
    step(0, 8'h00, 8'h00, 1, 0);
    for (int k = 0; k < 20; k++) step(0, 8'h40, 8'h40, 6, 1);
    step(0, 8'h00, 8'h00, 6, 0);
    step(0, 8'h20, 8'h20, 5, 1);
    step(0, 8'hFF, 8'h20, 5, 1);
    step(1, 8'hFF, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 8'hFF, 8'h01, 0, 1);
    step(0, 8'hFF, 8'h02, 1, 1);
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one resource among eight requesters. It tracks which requester holds the grant, limits how long a holder may keep it while others wait, and drives a one-hot grant vector through an enabled 3-to-8 decode stage. It sits between eight request sources and the shared datapath or bus in the lab designs, and drives that resource's select and enable.

## Interface
Parameters:
- MAX_HOLD, default 15: maximum consecutive grant cycles while another requester is waiting.
  - Legal range is 1..15.
  - 0 is illegal; reject it with an elaboration-time check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request vector.
  - Bit i high means requester i wants the resource.
  - A holder keeps req high for as long as it needs the grant.
- gnt  output  8  one-hot grant vector. All zero when no grant is active.
- gnt_idx  output  3  index of the current or last granted requester.
- gnt_valid  output  1  high while a grant is active.

## Operation
- Two states:
  - IDLE: no grant active.
  - GRANT: gnt_idx owns the resource.
- ptr (3 bit) holds the last granted index.
- Arbitration search:
  - Scan req starting at (ptr+1) mod 8 and wrap 7→0.
  - The first set bit wins.
  - Each new grant loads ptr with the winner's index.
- IDLE:
  - If req != 0, the winner is selected and the state moves to GRANT.
  - hold_cnt clears to 0.
  - Otherwise the state stays IDLE.
- GRANT, release (req[gnt_idx]==0):
  - If other requests are pending, arbitrate in the same cycle. The new grant appears on the next edge with no idle bubble.
  - If no requests are pending, return to IDLE.
- GRANT, forced rotation (hold_cnt == MAX_HOLD-1, holder still requesting, at least one other req bit set):
  - Arbitrate starting from gnt_idx+1.
  - The holder loses the grant on the next edge.
- GRANT, no contention: the holder keeps the grant indefinitely. hold_cnt saturates at MAX_HOLD-1.
- hold_cnt:
  - 4 bits.
  - Clears on every new grant.
  - Increments each GRANT cycle and saturates.
- Output decode:
  - gnt = decode(gnt_idx) gated by gnt_valid.
  - A disabled decode gives 8'h00.
- Reset: on the next edge the block forces state=IDLE, ptr=7, hold_cnt=0, gnt_idx=0, gnt_valid=0 and gnt=8'h00.
  - With ptr=7, the first search after reset starts at requester 0.
  - Reset mid-grant drops the grant immediately. No completion cycle is given.

## Timing
- Registered outputs.
  - A request sampled at edge N while IDLE gives the grant visible after edge N, i.e. 1-cycle latency.
- Release:
  - Holder drops req before edge N.
  - gnt changes to the new winner, or to 0, after edge N.
- Under contention each holder sees gnt for at most MAX_HOLD consecutive cycles.
- Simultaneous release and forced rotation: treat as a release. The search is the same and the result is identical.
- A new request arriving in the same cycle as a rotation is included in that search.
- req bits of non-holders are don't-care to the holder's grant, apart from their rotation trigger.
- No combinational path from req to gnt.

## Structure
- Shared package/header holds:
  - N_REQ=8
  - IDX_W=3
  - HOLD_W=4
  - state encodings ST_IDLE and ST_GRANT.
- One sub-module, rr_grant_decode.
  - Purely combinational: enabled 3-to-8 decode of gnt_idx with gnt_valid as enable.
  - Instantiated once.
- The rotating priority search stays in the top as a loop over the 8 offsets from ptr+1.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with req=8'hFF.
  - Required: gnt=8'h00, gnt_idx=0, gnt_valid=0 throughout.
  - After release of rst: first gnt=8'h01.
- Single requester:
  - Stimulus: req=8'h04.
  - Required: after 1 cycle gnt=8'h04 and gnt_idx=2, held while req is high.
  - Stimulus: drop req.
  - Required: next cycle gnt=8'h00 and gnt_valid=0.
- Full contention:
  - Stimulus: MAX_HOLD=4, req=8'hFF held.
  - Required: grants visit 0,1,…,7,0 for exactly 4 cycles each, no gaps.
- Release handoff:
  - Stimulus: requester 3 holds; req=8'h2A (bits 1, 3, 5); requester 3 releases.
  - Required: next cycle gnt=8'h20.
  - Stimulus: requester 5 releases.
  - Required: gnt=8'h02.
- No contention:
  - Stimulus: MAX_HOLD=4, req=8'h40 for 20 cycles.
  - Required: gnt=8'h40 continuously, no forced drop.
- Reset mid-grant:
  - Stimulus: pulse rst during requester 5's grant, with req=8'hFF.
  - Required: gnt=8'h00 after the edge.
  - Required: the next grant goes to requester 0, not 6.
